// File: rtl/red_pitaya_hk_pkg.sv
// Shared types and defaults for the housekeeping bus arbiter.
package red_pitaya_hk_pkg;

  localparam int HK_AW    = 32;
  localparam int HK_DW    = 32;
  localparam int HK_TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } hk_state_e;

endpackage

// File: rtl/red_pitaya_hk_arb_port.sv
// One-deep pending request slot for a single requester; pulses arriving
// while the slot is occupied are dropped and flagged in a sticky ovf bit.
module red_pitaya_hk_arb_port
  import red_pitaya_hk_pkg::*;
#(
  parameter int AW = HK_AW,
  parameter int DW = HK_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          wen_i,
  input  logic          ren_i,
  input  logic          clr_i,
  output logic          pend_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          wen_o,
  output logic          ren_o,
  output logic          ovf_o
);

  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end
    // clr_i only fires while pending, so it never races an accepted pulse
    if (wen_i || ren_i) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d  = 1'b1;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        wen_d   = wen_i;
        ren_d   = ren_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pend_o  = pend_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wen_o   = wen_q;
  assign ren_o   = ren_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/red_pitaya_hk_arb.sv
// Two-requester round-robin arbiter in front of the housekeeping slave bus.
// Define HK_ARB_TIMEOUT_EN to abort a WAIT lasting TMO cycles with an error ack.
module red_pitaya_hk_arb
  import red_pitaya_hk_pkg::*;
#(
  parameter int AW  = HK_AW,
  parameter int DW  = HK_DW,
  parameter int TMO = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_wen,
  input  logic          m0_ren,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_wen,
  input  logic          m1_ren,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_wen,
  output logic          s_ren,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  input  logic          s_err,
  output logic          busy_o,
  output logic          grant_o,
  output logic [1:0]    ovf_o
);

  genvar gi;

  generate
    if (TMO < 1 || TMO > 255) begin : g_tmo_range
      $error("red_pitaya_hk_arb: TMO must be within 1..255");
    end
  endgenerate

  logic [AW-1:0] req_addr   [2];
  logic [DW-1:0] req_wdata  [2];
  logic [AW-1:0] slot_addr  [2];
  logic [DW-1:0] slot_wdata [2];
  logic [1:0]    req_wen, req_ren, slot_wen, slot_ren;
  logic [1:0]    pend, clr, ovf;

  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wen      = {m1_wen, m0_wen};
  assign req_ren      = {m1_ren, m0_ren};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      red_pitaya_hk_arb_port #(
        .AW (AW),
        .DW (DW)
      ) u_port (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (req_addr[gi]),
        .wdata_i (req_wdata[gi]),
        .wen_i   (req_wen[gi]),
        .ren_i   (req_ren[gi]),
        .clr_i   (clr[gi]),
        .pend_o  (pend[gi]),
        .addr_o  (slot_addr[gi]),
        .wdata_o (slot_wdata[gi]),
        .wen_o   (slot_wen[gi]),
        .ren_o   (slot_ren[gi]),
        .ovf_o   (ovf[gi])
      );
    end
  endgenerate

  hk_state_e     state_q, state_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic          s_wen_q, s_wen_d;
  logic          s_ren_q, s_ren_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata_q [2];
  logic [DW-1:0] rdata_d [2];
  logic          sel, done, rsp_err;
  logic [DW-1:0] rsp_data;

`ifdef HK_ARB_TIMEOUT_EN
  localparam logic [HK_TMO_W-1:0] TMO_LAST = HK_TMO_W'(TMO - 1);
  logic [HK_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wen_d    = 1'b0;
    s_ren_d    = 1'b0;
    ack_d      = 2'b00;
    err_d      = 2'b00;
    rdata_d[0] = rdata_q[0];
    rdata_d[1] = rdata_q[1];
    clr        = 2'b00;
    sel        = 1'b0;
    done       = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
`ifdef HK_ARB_TIMEOUT_EN
    tmo_cnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        // rr_q names the requester that wins a tie
        if (|pend) begin
          sel       = (&pend) ? rr_q : pend[1];
          grant_d   = sel;
          state_d   = ISSUE;
          s_addr_d  = slot_addr[sel];
          s_wdata_d = slot_wdata[sel];
          s_wen_d   = slot_wen[sel];
          s_ren_d   = slot_ren[sel];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (s_ack) begin
          done     = 1'b1;
          rsp_data = s_rdata;
          rsp_err  = s_err;
        end
`ifdef HK_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          done    = 1'b1;
          rsp_err = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d = IDLE;
      rr_d    = ~grant_q;
      if (grant_q) begin
        ack_d[1]   = 1'b1;
        err_d[1]   = rsp_err;
        rdata_d[1] = rsp_data;
        clr[1]     = 1'b1;
      end else begin
        ack_d[0]   = 1'b1;
        err_d[0]   = rsp_err;
        rdata_d[0] = rsp_data;
        clr[0]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wen_q    <= 1'b0;
      s_ren_q    <= 1'b0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
`ifdef HK_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wen_q    <= s_wen_d;
      s_ren_q    <= s_ren_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
`ifdef HK_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wen    = s_wen_q;
  assign s_ren    = s_ren_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign busy_o   = (state_q != IDLE);
  assign grant_o  = grant_q;
  assign ovf_o    = ovf;

endmodule

// File: doc/red_pitaya_hk_arb.md
RED_PITAYA_HK_ARB -- requirements
Module: red_pitaya_hk_arb

Interface
REQ-001 SHALL have parameter AW, default 32, system-bus address width.
REQ-002 SHALL have parameter DW, default 32, system-bus data width.
REQ-003 SHALL have parameter TMO, default 255, timeout in clk_i cycles, range 1..255.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports m0_addr/m1_addr (input, AW), m0_wdata/m1_wdata (input, DW), m0_wen/m1_wen (input, 1) and m0_ren/m1_ren (input, 1), the requester buses; wen/ren are single-cycle pulses.
REQ-007 SHALL have ports m0_rdata/m1_rdata (output, DW), m0_ack/m1_ack (output, 1) and m0_err/m1_err (output, 1), the requester responses.
REQ-008 SHALL have ports s_addr (output, AW), s_wdata (output, DW), s_wen (output, 1) and s_ren (output, 1), the shared housekeeping slave bus.
REQ-009 SHALL have ports s_rdata (input, DW), s_ack (input, 1) and s_err (input, 1), the slave response.
REQ-010 SHALL have ports busy_o (output, 1, not IDLE), grant_o (output, 1, index of the served requester) and ovf_o (output, 2, sticky per-requester drop flags).

Function
REQ-011 SHALL latch a request pulse (addr, wdata, wen, ren) into a one-deep pending slot per requester on the following edge.
REQ-012 SHALL drop a pulse that arrives while that requester's slot is pending, and SHALL set the requester's ovf_o bit until reset.
REQ-013 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-014 SHALL, in IDLE with any slot pending, select one requester round-robin; with both pending, the requester not served last wins, and after reset requester 0 wins.
REQ-015 SHALL, in ISSUE, drive s_addr, s_wdata, s_wen and s_ren from the selected slot for exactly one cycle, then go to WAIT.
REQ-016 SHALL, in WAIT on s_ack=1, register s_rdata and s_err to the granted requester's rdata/err with a one-cycle ack, clear its slot, update the round-robin pointer and return to IDLE.
REQ-017 SHALL hold the non-granted requester's ack and err at 0; rdata SHALL hold its last value.
REQ-018 SHALL deliver latency request pulse cycle 0 -> s_wen/s_ren cycle 2 -> m_ack cycle 4 when the slave acks one cycle after enable.
REQ-019 SHALL accept a new pulse from a requester in the same cycle as its m_ack.
REQ-020 SHALL ignore s_ack in IDLE and ISSUE.
REQ-021 SHALL keep s_wen and s_ren at 0 outside ISSUE.

Reset
REQ-022 SHALL, on rst_i, immediately force state IDLE, all slots empty, round-robin pointer 0, timeout counter 0, and every output 0 (including ovf_o and all rdata).
REQ-023 SHALL, on reset mid-transaction, discard the transaction without any ack; a late s_ack after reset SHALL be ignored.

Configuration
REQ-024 SHALL, with HK_ARB_TIMEOUT_EN defined, count WAIT cycles and, on reaching TMO without s_ack, complete the transaction as m_ack=1, m_err=1, m_rdata=0, then proceed exactly as REQ-016.
REQ-025 SHALL, without HK_ARB_TIMEOUT_EN, omit the counter entirely and wait in WAIT indefinitely for s_ack.

Structure
REQ-026 SHALL take its state enum, the AW/DW defaults and the TMO counter width from package red_pitaya_hk_pkg.
REQ-027 SHALL implement the pending slot with drop/ovf logic as sub-module red_pitaya_hk_arb_port, instantiated twice.

Verification
REQ-028 SHALL cover: m0 read of addr 0x4, slave acks next cycle with 0xDEADBEEF -> s_ren in cycle 2, m0_ack=1 and m0_rdata=0xDEADBEEF in cycle 4, m1_ack=0.
REQ-029 SHALL cover: m0 and m1 write in the same cycle after reset -> m0 served first, then m1; grant_o reads 0 then 1.
REQ-030 SHALL cover: m1 issues a second pulse before its m_ack -> second pulse dropped, ovf_o=2'b10, only one s_wen seen.
REQ-031 SHALL cover: HK_ARB_TIMEOUT_EN defined, TMO=8, slave never acks -> m0_ack=1, m0_err=1, m0_rdata=0 after 8 WAIT cycles; a later s_ack is ignored.
REQ-032 SHALL cover: rst_i asserted during WAIT -> all outputs 0 immediately, no ack to any requester, next request served normally.
